// File: rtl/data_sync_tx_ctrl_pkg.sv
// Shared constants for the source-side launcher of the Data_Sync bus synchronizer:
// FSM encodings, requester indices and the counter-width helper.
package data_sync_tx_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/data_sync_tx_ctrl_ack_sync.sv
// Level synchronizer bringing the destination acknowledge into the CLK domain.
module ack_sync #(
    parameter int NUM_OF_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_i,
    output logic sync_o
);

    logic [NUM_OF_STAGES-1:0] sync_q;

    // Shift chain; only the last stage is safe to use.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= {NUM_OF_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[NUM_OF_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[NUM_OF_STAGES-1];

endmodule

// File: rtl/data_sync_tx_ctrl.sv
// Two-requester round-robin launcher driving unsync_bus/bus_enable with a 4-phase
// handshake closed by the synchronized destination acknowledge, with timeout recovery.
module data_sync_tx_ctrl
    import data_sync_tx_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_OF_STAGES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    input  logic [BUS_WIDTH-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [BUS_WIDTH-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 done_pulse,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int CNT_W = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 grant_q, grant_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 bus_en_q, bus_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 terr_q, terr_d;
    logic                 tflag_q, tflag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 run_q;

    logic ack_s;
    logic winner_s;
    logic accept_s;
    logic timeout_hit_s;
    logic set_err_s;

    ack_sync #(
        .NUM_OF_STAGES(NUM_OF_STAGES)
    ) u_ack_sync (
        .CLK    (CLK),
        .RST    (RST),
        .async_i(ack_async),
        .sync_o (ack_s)
    );

    // Round-robin pick; a lone valid wins regardless of the pointer.
    always_comb begin
        winner_s = REQ0;
        if (req0_valid && req1_valid) begin
            winner_s = ptr_q;
        end else if (req0_valid) begin
            winner_s = REQ0;
        end else begin
            winner_s = REQ1;
        end
    end

    // run_q keeps ready low while reset is held and for the release cycle.
    assign accept_s      = run_q && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready    = accept_s && (winner_s == REQ0);
    assign req1_ready    = accept_s && (winner_s == REQ1);
    assign timeout_hit_s = TO_EN && (cnt_q == CNT_LAST);

    // Handshake sequencing; bus_enable is a flop so the destination never sees a glitch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        bus_d     = bus_q;
        bus_en_d  = bus_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tflag_d   = tflag_q;
        cnt_d     = cnt_q;
        set_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_REQ;
                    bus_d    = (winner_s == REQ1) ? req1_data : req0_data;
                    grant_d  = winner_s;
                    ptr_d    = ~winner_s;
                    bus_en_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    tflag_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d  = ST_RELEASE;
                    bus_en_d = 1'b0;
                end else if (timeout_hit_s) begin
                    state_d   = ST_RELEASE;
                    bus_en_d  = 1'b0;
                    tflag_d   = 1'b1;
                    set_err_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = ~tflag_q;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bus_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Sticky timeout flag: a new abort beats a simultaneous clear.
    always_comb begin
        if (set_err_s) begin
            terr_d = 1'b1;
        end else if (err_clr) begin
            terr_d = 1'b0;
        end else begin
            terr_d = terr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= REQ0;
            grant_q  <= REQ0;
            bus_q    <= {BUS_WIDTH{1'b0}};
            bus_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            tflag_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            bus_q    <= bus_d;
            bus_en_q <= bus_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            tflag_q  <= tflag_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
        end
    end

    assign unsync_bus  = bus_q;
    assign bus_enable  = bus_en_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign done_pulse  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_data_sync_tx_ctrl.sv
// Scoreboard bench for data_sync_tx_ctrl with a simple destination model that
// echoes bus_enable back on ack_async three cycles later.
module tb_data_sync_tx_ctrl;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [BW-1:0] req0_data, req1_data, unsync_bus;
    logic          ack_async = 1'b0;
    logic          bus_enable, busy, grant_id, done_pulse, timeout_err, err_clr;

    int            n_checks = 0;
    int            n_errs   = 0;
    int            done_cnt = 0;
    logic          dst_alive = 1'b1;
    logic [2:0]    dst_pipe  = 3'b000;
    logic [8:0]    sb_q[$];

    data_sync_tx_ctrl #(
        .BUS_WIDTH(BW), .NUM_OF_STAGES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ack_async(ack_async), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
        .busy(busy), .grant_id(grant_id), .done_pulse(done_pulse),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, busy, 1'b0);
    endtask

    // Destination: ack_async is bus_enable delayed by three falling edges.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) dst_pipe = 3'b000;
            else      dst_pipe = {dst_pipe[1:0], bus_enable & dst_alive};
            ack_async = dst_pipe[2];
        end
    end

    // Monitor: pops the scoreboard on each new launch, counts done pulses.
    initial begin
        logic       prev_be;
        logic [8:0] exp_w;
        prev_be = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (done_pulse) done_cnt++;
            if (req0_ready || req1_ready)
                check_val("ready_onehot", {req0_ready, req1_ready}, (req0_ready ? 2'b10 : 2'b01));
            if (bus_enable && !prev_be) begin
                check_val("sb_nonempty", (sb_q.size() > 0), 1'b1);
                if (sb_q.size() > 0) begin
                    exp_w = sb_q.pop_front();
                    check_val("launch_word", {grant_id, unsync_bus}, exp_w);
                end
            end
            prev_be = bus_enable;
        end
    end

    initial begin
        int d0;
        int n;
        int accepts;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = 8'h00; req1_data  = 8'h00;
        err_clr    = 1'b0;

        // Reset state, including no ready while reset is held.
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) tick();
        check_val("rst_bus",   unsync_bus, 8'h00);
        check_val("rst_be",    bus_enable, 1'b0);
        check_val("rst_busy",  busy, 1'b0);
        check_val("rst_grant", grant_id, 1'b0);
        check_val("rst_done",  done_pulse, 1'b0);
        check_val("rst_err",   timeout_err, 1'b0);
        check_val("rst_ready", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0; req1_valid = 1'b0;
        RST = 1'b1;
        repeat (2) tick();

        // Contention: alternating grants starting with req0.
        sb_q.push_back({1'b0, 8'h11}); sb_q.push_back({1'b1, 8'h22});
        sb_q.push_back({1'b0, 8'h11}); sb_q.push_back({1'b1, 8'h22});
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        accepts = 0;
        for (int c = 0; c < 400 && accepts < 4; c++) begin
            #1;
            if (req0_ready || req1_ready) accepts++;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_val("contention_accepts", accepts, 4);
        wait_idle("contention_idle");
        tick();

        // Single request, ack latency and bus stability.
        d0 = done_cnt;
        sb_q.push_back({1'b0, 8'hA5});
        req0_data = 8'hA5; req0_valid = 1'b1;
        #1;
        check_val("single_ready0", req0_ready, 1'b1);
        check_val("single_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req0_data = 8'h3C;
        check_val("single_be",    bus_enable, 1'b1);
        check_val("single_bus",   unsync_bus, 8'hA5);
        check_val("single_grant", grant_id, 1'b0);
        n = 0;
        while (!ack_async && n < 50) begin tick(); n++; end
        check_val("ack_seen", ack_async, 1'b1);
        check_val("bus_hold_req", unsync_bus, 8'hA5);
        n = 0;
        while (bus_enable && n < 50) begin tick(); n++; end
        check_val("be_drop_latency", n, NS);
        check_val("bus_hold_rel", unsync_bus, 8'hA5);
        wait_idle("single_idle");
        tick();
        check_val("single_done", done_cnt - d0, 1);
        check_val("bus_hold_idle", unsync_bus, 8'hA5);
        check_val("single_grant_end", grant_id, 1'b0);

        // Stopped destination: timeout after exactly TO REQ cycles.
        dst_alive = 1'b0;
        d0 = done_cnt;
        sb_q.push_back({1'b1, 8'h5A});
        req1_data = 8'h5A; req1_valid = 1'b1;
        #1;
        check_val("to_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (bus_enable && n < 50) begin tick(); n++; end
        check_val("to_req_cycles", n, TO);
        check_val("to_err_set", timeout_err, 1'b1);
        wait_idle("to_idle");
        tick();
        check_val("to_no_done", done_cnt - d0, 0);

        // Error clear, then clear colliding with a new timeout.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("err_cleared", timeout_err, 1'b0);
        sb_q.push_back({1'b0, 8'hC3});
        req0_data = 8'hC3; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        err_clr = 1'b1;
        n = 0;
        while (bus_enable && n < 50) begin tick(); n++; end
        err_clr = 1'b0;
        check_val("err_set_wins", timeout_err, 1'b1);
        wait_idle("to2_idle");
        tick();

        // Reset in the middle of REQ.
        d0 = done_cnt;
        sb_q.push_back({1'b1, 8'h96});
        req1_data = 8'h96; req1_valid = 1'b1;
        #1;
        tick();
        req1_valid = 1'b0;
        tick();
        check_val("mid_be_before", bus_enable, 1'b1);
        RST = 1'b0;
        #1;
        check_val("mid_be",    bus_enable, 1'b0);
        check_val("mid_bus",   unsync_bus, 8'h00);
        check_val("mid_busy",  busy, 1'b0);
        check_val("mid_grant", grant_id, 1'b0);
        check_val("mid_err",   timeout_err, 1'b0);
        tick();
        RST = 1'b1;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_val("ptr_after_rst", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check_val("mid_no_done", done_cnt - d0, 0);

        // Fresh req1 transfer completes normally after reset.
        dst_alive = 1'b1;
        d0 = done_cnt;
        sb_q.push_back({1'b1, 8'h77});
        req1_data = 8'h77; req1_valid = 1'b1;
        #1;
        check_val("fresh_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_idle("fresh_idle");
        tick();
        check_val("fresh_done",  done_cnt - d0, 1);
        check_val("fresh_grant", grant_id, 1'b1);
        check_val("fresh_err",   timeout_err, 1'b0);

        check_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
